// File: rtl/int_alu_issue.sv
// Issue controller for the integer ALU cluster: launches ops, waits on multicycle units, hands results to writeback.
// Optional watchdog in WAIT is built when INTALU_TIMEOUT_EN is defined.
module int_alu_issue #(
    parameter int unsigned TAG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_aluk,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [1:0]        alu_k,
    output logic [3:0]        alu_mux,
    output logic              int_exe,
    input  logic              mult_ready,
    input  logic              div_ready,
    input  logic [31:0]       alu_out1,
    input  logic [31:0]       alu_out2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_lo,
    output logic [31:0]       res_hi,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_div0,
    output logic              res_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MUX_W  = 4;

    localparam logic [1:0] OP_ALU  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_MOVE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_HOLD
    } state_t;

    // A zero limit would make the watchdog compare meaningless.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("int_alu_issue: TIMEOUT_CYCLES must be nonzero");
    end

    state_t              state, state_nxt;
    logic [1:0]          op_q, op_nxt;
    logic [DATA_W-1:0]   a_nxt, b_nxt, lo_nxt, hi_nxt;
    logic [1:0]          k_nxt;
    logic [MUX_W-1:0]    mux_nxt;
    logic [TAG_W-1:0]    tag_nxt;
    logic                div0_nxt;
    logic                req_ready_nxt, res_valid_nxt, int_exe_nxt;
    logic                unit_ready;

`ifdef INTALU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    wd_cnt, wd_cnt_nxt;
    logic                err_q, err_nxt;
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= OP_ALU;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_k     <= '0;
            alu_mux   <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            res_tag   <= '0;
            res_div0  <= 1'b0;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            int_exe   <= 1'b0;
`ifdef INTALU_TIMEOUT_EN
            wd_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            alu_a     <= a_nxt;
            alu_b     <= b_nxt;
            alu_k     <= k_nxt;
            alu_mux   <= mux_nxt;
            res_lo    <= lo_nxt;
            res_hi    <= hi_nxt;
            res_tag   <= tag_nxt;
            res_div0  <= div0_nxt;
            req_ready <= req_ready_nxt;
            res_valid <= res_valid_nxt;
            int_exe   <= int_exe_nxt;
`ifdef INTALU_TIMEOUT_EN
            wd_cnt    <= wd_cnt_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        a_nxt         = alu_a;
        b_nxt         = alu_b;
        k_nxt         = alu_k;
        mux_nxt       = alu_mux;
        lo_nxt        = res_lo;
        hi_nxt        = res_hi;
        tag_nxt       = res_tag;
        div0_nxt      = res_div0;
        int_exe_nxt   = 1'b0;
        req_ready_nxt = 1'b0;
        res_valid_nxt = 1'b0;
        unit_ready    = (op_q == OP_MUL) ? mult_ready : div_ready;
`ifdef INTALU_TIMEOUT_EN
        wd_cnt_nxt    = wd_cnt;
        err_nxt       = err_q;
`endif

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt   = S_ISSUE;
                    op_nxt      = req_op;
                    a_nxt       = req_a;
                    b_nxt       = req_b;
                    k_nxt       = req_aluk;
                    mux_nxt     = MUX_W'(req_op);
                    tag_nxt     = req_tag;
                    div0_nxt    = 1'b0;
                    // Launch decision made at accept so the pulse lines up with ISSUE.
                    int_exe_nxt = (req_op == OP_MUL) ||
                                  ((req_op == OP_DIV) && (req_b != '0));
`ifdef INTALU_TIMEOUT_EN
                    err_nxt     = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                if ((op_q == OP_ALU) || (op_q == OP_MOVE)) begin
                    lo_nxt    = alu_out1;
                    hi_nxt    = '0;
                    state_nxt = S_HOLD;
                end else if ((op_q == OP_DIV) && (alu_b == '0)) begin
                    lo_nxt    = 32'hFFFF_FFFF;
                    hi_nxt    = alu_a;
                    div0_nxt  = 1'b1;
                    state_nxt = S_HOLD;
                end else begin
                    state_nxt = S_GUARD;
                end
            end
            S_GUARD: begin
                // Ready flag may still be high from the previous op here.
`ifdef INTALU_TIMEOUT_EN
                wd_cnt_nxt = '0;
`endif
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (unit_ready) begin
                    lo_nxt    = alu_out1;
                    hi_nxt    = (op_q == OP_DIV) ? alu_out2 : '0;
                    state_nxt = S_HOLD;
                end
`ifdef INTALU_TIMEOUT_EN
                else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    lo_nxt    = '0;
                    hi_nxt    = '0;
                    err_nxt   = 1'b1;
                    state_nxt = S_HOLD;
                end else begin
                    wd_cnt_nxt = wd_cnt + CNT_W'(1);
                end
`endif
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        req_ready_nxt = (state_nxt == S_IDLE);
        res_valid_nxt = (state_nxt == S_HOLD);
    end

endmodule

// File: tb/tb_int_alu_issue.sv
// Scoreboard bench for int_alu_issue with a behavioural model of the ALU cluster.
module tb_int_alu_issue;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned TO    = 8;

    localparam logic [1:0] OP_ALU  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_MOVE = 2'd3;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [1:0]       req_op, req_aluk;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      alu_a, alu_b;
    logic [1:0]       alu_k;
    logic [3:0]       alu_mux;
    logic             int_exe, mult_ready, div_ready;
    logic [31:0]      alu_out1, alu_out2;
    logic             res_valid, res_ready;
    logic [31:0]      res_lo, res_hi;
    logic [TAG_W-1:0] res_tag;
    logic             res_div0, res_err;

    int_alu_issue #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_aluk(req_aluk),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_k(alu_k), .alu_mux(alu_mux), .int_exe(int_exe),
        .mult_ready(mult_ready), .div_ready(div_ready), .alu_out1(alu_out1), .alu_out2(alu_out2),
        .res_valid(res_valid), .res_ready(res_ready), .res_lo(res_lo), .res_hi(res_hi),
        .res_tag(res_tag), .res_div0(res_div0), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Cluster model: ready drops one cycle after launch is seen, rises lat_cfg cycles later.
    int          lat_cfg;
    bit          never;
    logic        pend;
    logic [3:0]  pmux;
    int          ccnt;
    logic [31:0] r1, r2, c_q1, c_q2, alu_f;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_ready <= 1'b1; div_ready <= 1'b1; pend <= 1'b0; pmux <= '0;
            ccnt <= 0; r1 <= '0; r2 <= '0; c_q1 <= '0; c_q2 <= '0;
        end else if (int_exe) begin
            pend <= 1'b1;
            pmux <= alu_mux;
            if (alu_mux == 4'd1) begin
                r1 <= 32'(alu_a[15:0]) * 32'(alu_b[15:0]);
                r2 <= '0;
            end else begin
                r1 <= alu_a / alu_b;
                r2 <= alu_a % alu_b;
            end
        end else if (pend) begin
            pend <= 1'b0;
            ccnt <= lat_cfg;
            if (pmux == 4'd1) mult_ready <= 1'b0; else div_ready <= 1'b0;
        end else if (ccnt > 1) begin
            ccnt <= ccnt - 1;
        end else if (ccnt == 1) begin
            ccnt <= 0;
            if (!never) begin
                c_q1 <= r1; c_q2 <= r2;
                if (pmux == 4'd1) mult_ready <= 1'b1; else div_ready <= 1'b1;
            end
        end
    end

    always_comb begin
        alu_f = '0;
        case (alu_k)
            2'd0: alu_f = alu_a + alu_b;
            2'd1: alu_f = alu_a - alu_b;
            2'd2: alu_f = alu_a & alu_b;
            default: alu_f = alu_a | alu_b;
        endcase
    end
    assign alu_out1 = (alu_mux == 4'd0) ? alu_f : (alu_mux == 4'd3) ? alu_a : c_q1;
    assign alu_out2 = c_q2;

    int cyc = 0;
    int exe_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (int_exe) exe_cnt <= exe_cnt + 1;
    end

    typedef struct {
        logic [31:0]      lo, hi;
        logic [TAG_W-1:0] tag;
        logic             div0, err;
        int               lat, exe;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_acc, exe_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] k, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag, input int l, input bit nv);
        exp_t e;
        int   n;
        e.lo = '0; e.hi = '0; e.tag = tag; e.div0 = 1'b0; e.err = 1'b0; e.lat = 1; e.exe = 0;
        case (op)
            OP_ALU: case (k)
                2'd0: e.lo = a + b;
                2'd1: e.lo = a - b;
                2'd2: e.lo = a & b;
                default: e.lo = a | b;
            endcase
            OP_MUL: begin
                e.lo = 32'(a[15:0]) * 32'(b[15:0]); e.lat = 3 + l; e.exe = 1;
            end
            OP_DIV: begin
                if (b == '0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.div0 = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b; e.lat = 3 + l; e.exe = 1;
                end
            end
            default: e.lo = a;
        endcase
        if (nv) begin
            e.lo = '0; e.hi = '0; e.err = 1'b1; e.lat = 2 + TO;
        end
        sb.push_back(e);
        lat_cfg = l; never = nv;
        req_op = op; req_aluk = k; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        exe_base = exe_cnt;
        @(posedge clk);
        @(negedge clk);
        t_acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   n = 0;
        while (!res_valid && n < 2000) begin @(negedge clk); n++; end
        if (!res_valid) begin
            check("res_valid_timeout", 32'(res_valid), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", 32'(cyc - t_acc), 32'(e.lat));
        check("res_lo", res_lo, e.lo);
        check("res_hi", res_hi, e.hi);
        check("res_tag", 32'(res_tag), 32'(e.tag));
        check("res_div0", 32'(res_div0), 32'(e.div0));
        check("res_err", 32'(res_err), 32'(e.err));
        check("exe_pulses", 32'(exe_cnt - exe_base), 32'(e.exe));
        if (hold > 0) begin
            req_op = OP_ALU; req_aluk = 2'd0; req_a = 32'h1111_1111; req_b = 32'h2; req_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_lo", res_lo, e.lo);
            check("hold_hi", res_hi, e.hi);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", 32'(res_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
        if (hold > 0) check("no_accept_in_hold", alu_a, e.lo);
    endtask

    int vcount;

    initial begin
        reset = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        req_op = '0; req_aluk = '0; req_a = '0; req_b = '0; req_tag = '0;
        lat_cfg = 3; never = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_int_exe", 32'(int_exe), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_mux", 32'(alu_mux), 32'd0);
        check("rst_res_lo", res_lo, 32'd0);
        check("rst_res_hi", res_hi, 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_res_div0", 32'(res_div0), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(OP_ALU, 2'd0, 32'd5, 32'd3, 5'd3, 0, 1'b0);            collect(0);
        issue(OP_MUL, 2'd0, 32'h0001_0003, 32'd7, 5'd4, 3, 1'b0);    collect(0);
        issue(OP_DIV, 2'd0, 32'd100, 32'd7, 5'd5, 2, 1'b0);          collect(0);
        issue(OP_DIV, 2'd0, 32'd100, 32'd0, 5'd6, 0, 1'b0);          collect(0);
        issue(OP_MOVE, 2'd1, 32'hDEAD_BEEF, 32'd1, 5'd7, 0, 1'b0);   collect(5);
        for (int i = 0; i < 6; i++) begin
            issue(OP_ALU, 2'(i), $urandom, $urandom, 5'(i + 8), 0, 1'b0);
            collect(0);
        end
        issue(OP_MUL, 2'd0, $urandom, $urandom, 5'd20, 1, 1'b0);     collect(0);
        issue(OP_DIV, 2'd0, $urandom, 32'($urandom_range(1, 1000)), 5'd21, 4, 1'b0); collect(0);

        // Launch pulse must collapse immediately on reset.
        issue(OP_MUL, 2'd0, 32'd9, 32'd9, 5'd22, 3, 1'b0);
        check("exe_before_rst", 32'(int_exe), 32'd1);
        #2 reset = 1'b0;
        #1 check("rst_issue_int_exe", 32'(int_exe), 32'd0);
        check("rst_issue_req_ready", 32'(req_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef INTALU_TIMEOUT_EN
        issue(OP_DIV, 2'd0, 32'd50, 32'd5, 5'd9, 1, 1'b1);           collect(0);
        issue(OP_DIV, 2'd0, 32'd50, 32'd5, 5'd10, 1, 1'b1);
        vcount = 0;
        repeat (4) begin @(negedge clk); if (res_valid) vcount++; end
`else
        issue(OP_DIV, 2'd0, 32'd50, 32'd5, 5'd9, 1, 1'b1);
        vcount = 0;
        repeat (1000) begin @(negedge clk); if (res_valid) vcount++; end
        check("no_watchdog_valid", 32'(vcount), 32'd0);
        check("no_watchdog_err", 32'(res_err), 32'd0);
`endif
        // Reset while parked in WAIT.
        #2 reset = 1'b0;
        #1 check("rst_wait_req_ready", 32'(req_ready), 32'd1);
        check("rst_wait_int_exe", 32'(int_exe), 32'd0);
        check("rst_wait_res_valid", 32'(res_valid), 32'd0);
        sb.delete();
        never = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(OP_DIV, 2'd0, 32'd81, 32'd9, 5'd30, 2, 1'b0);          collect(0);
        issue(OP_ALU, 2'd3, 32'hF0F0_0000, 32'h0000_0F0F, 5'd31, 0, 1'b0); collect(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/int_alu_issue.md
# int_alu_issue

Issue controller that drives the integer ALU cluster (single-cycle ALU, multicycle multiplier, multicycle divider) from the execute stage. It accepts one operation per valid/ready handshake and launches it on the cluster's operand/select/execute lines. For multicycle units it waits on the cluster's per-unit ready flags, captures both result words, and presents them to writeback under a second valid/ready handshake. It is the initiator end of the cluster's execute/ready protocol.

## Interface
- TAG_W, 5, width of the pass-through destination tag
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with INTALU_TIMEOUT_EN
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (one clock; reset asserted when low)
- req_valid  in  1  operation request valid
- req_ready  out  1  controller can accept a request
- req_op  in  2  00 ALU, 01 MUL, 10 DIV, 11 MOVE (pass A)
- req_aluk  in  2  ALU function select, forwarded unchanged
- req_a, req_b  in  32  operands
- req_tag  in  TAG_W  destination tag
- alu_a, alu_b  out  32  registered operands to cluster
- alu_k  out  2  registered ALU function
- alu_mux  out  4  result select: ALU 0, MUL 1, DIV 2, MOVE 3
- int_exe  out  1  one-cycle launch pulse for MUL/DIV
- mult_ready, div_ready  in  1  cluster unit ready flags
- alu_out1, alu_out2  in  32  cluster result / remainder
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts result
- res_lo, res_hi  out  32  captured out1 / out2 (remainder for DIV, else 0)
- res_tag  out  TAG_W  tag of the op
- res_div0  out  1  DIV with zero divisor
- res_err  out  1  watchdog expiry (0 without macro)

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, HOLD.
- IDLE: req_ready=1. On req_valid, register operands, aluk, tag, and alu_mux per op. Go to ISSUE.
- ISSUE, ALU/MOVE: capture alu_out1 into res_lo and set res_hi=0. Go to HOLD.
- ISSUE, DIV with req_b==0: no launch. Set res_lo=32'hFFFF_FFFF, res_hi=A, res_div0=1. Go to HOLD.
- ISSUE, MUL/DIV otherwise: int_exe=1 for this cycle only. Go to GUARD.
- MUL uses only the low 16 bits of each operand, and the full 32-bit operands are still driven.
- GUARD: one cycle in which the ready flags are ignored, because the flag may still be high from the previous op. Go to WAIT.
- WAIT: sample mult_ready for MUL or div_ready for DIV. On 1, capture alu_out1 to res_lo and alu_out2 to res_hi (DIV) or 0 (MUL). Go to HOLD.
- HOLD: res_valid=1. All res_* fields stay stable until res_ready=1, then go to IDLE.
- res_ready is ignored outside HOLD.
- alu_a, alu_b, alu_k and alu_mux stay stable from ISSUE through HOLD, then hold their value in IDLE until the next accept.
- Reset mid-operation: immediate return to IDLE. int_exe and res_valid drop asynchronously. The cluster shares the reset and is cleared by it.

## Timing
- Reset values: req_ready=1; res_valid=0; int_exe=0; alu_a, alu_b, res_lo, res_hi=0; alu_k=0; alu_mux=0; res_tag=0; res_div0=0; res_err=0.
- Accept at edge T0 (req_valid & req_ready).
- ALU/MOVE and DIV-by-zero: res_valid high after T1 (latency 1).
- MUL/DIV: int_exe high T0–T1, GUARD T1–T2, ready first sampled at T2. Minimum latency is 3 cycles; actual latency is 2 + (cycles until ready).
- Throughput: at most one op per 2 cycles. No accept while in HOLD.

## Configuration
- INTALU_TIMEOUT_EN defined:
  - WAIT counts cycles from 0.
  - If the counter reaches TIMEOUT_CYCLES with no ready, go to HOLD with res_lo=res_hi=0 and res_err=1.
  - The counter clears on WAIT entry.
- Undefined: WAIT has no limit, res_err is tied to 0, and no counter is built.

## Test plan
- Reset with the FSM in WAIT -> req_ready=1, int_exe=0, res_valid=0 within the same cycle.
- ALU op with A=5, B=3, aluk=ADD, cluster out1=8 -> res_valid one cycle after accept; res_lo=8, res_hi=0, tag echoed.
- MUL with A=0x0001_0003, B=7; mult_ready held high from the previous op, then low, then high 4 cycles after launch -> exactly one int_exe pulse, stale ready ignored in GUARD, res_lo=21.
- DIV with A=100, B=7 -> res_lo=14, res_hi=2. DIV with B=0 -> no int_exe, res_lo=0xFFFF_FFFF, res_hi=100, res_div0=1, latency 1.
- res_ready held low 5 cycles in HOLD -> res_* stable, req_ready=0, a new req_valid is not accepted.
- With INTALU_TIMEOUT_EN and TIMEOUT_CYCLES=8, div_ready never rises -> res_valid with res_err=1 at cycle 8 of WAIT. Without the macro -> no res_valid after 1000 cycles.
